// File: rtl/riscv_pkg.sv
// RISC-V opcode, load-funct3 and write-back-select encodings shared by the W stage.
// Also provides the writes_rd decode.
package riscv_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  localparam logic [1:0] WB_SEL_ALU = 2'd0;
  localparam logic [1:0] WB_SEL_MEM = 2'd1;
  localparam logic [1:0] WB_SEL_PC4 = 2'd2;

  // STORE, BRANCH, MISC-MEM and unknown opcodes all land in default.
  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR,
      OPC_LOAD, OPC_OPIMM, OPC_OP, OPC_SYSTEM: writes_rd = 1'b1;
      default:                                 writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// M-stage -> W-stage bundle plus RegFile write port and decode forwarding controls.
// Optional instret output when WB_INSTRET_EN is defined.
interface writeback_stage_if #(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
);
  logic             stall;
  logic             flush;
  logic             m_valid;
  logic [31:0]      m_inst;
  logic [XLEN-1:0]  m_alu;
  logic [XLEN-1:0]  m_pc4;
  logic [XLEN-1:0]  m_dmem_rdata;
  logic [1:0]       m_wb_sel;
  logic [31:0]      d_inst;
  logic             rf_we;
  logic [RF_AW-1:0] rf_wa;
  logic [XLEN-1:0]  rf_wd;
  logic             wb_valid;
  logic             wb2d_a;
  logic             wb2d_b;
  logic [XLEN-1:0]  wb_val;
`ifdef WB_INSTRET_EN
  logic [63:0]      instret;

  modport master (
    output stall, flush, m_valid, m_inst, m_alu, m_pc4, m_dmem_rdata, m_wb_sel, d_inst,
    input  rf_we, rf_wa, rf_wd, wb_valid, wb2d_a, wb2d_b, wb_val, instret
  );
  modport slave (
    input  stall, flush, m_valid, m_inst, m_alu, m_pc4, m_dmem_rdata, m_wb_sel, d_inst,
    output rf_we, rf_wa, rf_wd, wb_valid, wb2d_a, wb2d_b, wb_val, instret
  );
`else
  modport master (
    output stall, flush, m_valid, m_inst, m_alu, m_pc4, m_dmem_rdata, m_wb_sel, d_inst,
    input  rf_we, rf_wa, rf_wd, wb_valid, wb2d_a, wb2d_b, wb_val
  );
  modport slave (
    input  stall, flush, m_valid, m_inst, m_alu, m_pc4, m_dmem_rdata, m_wb_sel, d_inst,
    output rf_we, rf_wa, rf_wd, wb_valid, wb2d_a, wb2d_b, wb_val
  );
`endif
endinterface

// File: rtl/load_extend.sv
// Combinational load byte/half extraction with sign/zero extension; zero latency.
// Misaligned halfwords ignore offset[0]; unknown funct3 passes the word through.
module load_extend
  import riscv_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rdata_i,
  input  logic [1:0]      offset_i,
  input  logic [2:0]      funct3_i,
  output logic [XLEN-1:0] result_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
  assign half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];

  always_comb begin
    result_o = rdata_i;
    case (funct3_i)
      F3_LB:   result_o = {{(XLEN-8){byte_sel[7]}}, byte_sel};
      F3_LBU:  result_o = {{(XLEN-8){1'b0}}, byte_sel};
      F3_LH:   result_o = {{(XLEN-16){half_sel[15]}}, half_sel};
      F3_LHU:  result_o = {{(XLEN-16){1'b0}}, half_sel};
      F3_LW:   result_o = rdata_i;
      default: result_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// W stage: registers M results, RegFile write + MW->D forwarding one cycle after capture.
// stall holds W, flush (priority) inserts a bubble; WB_INSTRET_EN adds a retired-instruction counter.
module writeback_stage
  import riscv_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int RF_AW = 5
) (
  input logic               clk,
  input logic               rst_n,
  writeback_stage_if.slave  bus
);

  logic            valid_q,  valid_d;
  logic [31:0]     inst_q,   inst_d;
  logic [XLEN-1:0] alu_q,    alu_d;
  logic [XLEN-1:0] pc4_q,    pc4_d;
  logic [XLEN-1:0] rdata_q,  rdata_d;
  logic [1:0]      wb_sel_q, wb_sel_d;

  always_comb begin
    valid_d  = valid_q;
    inst_d   = inst_q;
    alu_d    = alu_q;
    pc4_d    = pc4_q;
    rdata_d  = rdata_q;
    wb_sel_d = wb_sel_q;
    if (bus.flush) begin
      valid_d  = 1'b0;
      inst_d   = '0;
      alu_d    = '0;
      pc4_d    = '0;
      rdata_d  = '0;
      wb_sel_d = '0;
    end else if (!bus.stall) begin
      valid_d  = bus.m_valid;
      inst_d   = bus.m_inst;
      alu_d    = bus.m_alu;
      pc4_d    = bus.m_pc4;
      rdata_d  = bus.m_dmem_rdata;
      wb_sel_d = bus.m_wb_sel;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q  <= 1'b0;
      inst_q   <= '0;
      alu_q    <= '0;
      pc4_q    <= '0;
      rdata_q  <= '0;
      wb_sel_q <= '0;
    end else begin
      valid_q  <= valid_d;
      inst_q   <= inst_d;
      alu_q    <= alu_d;
      pc4_q    <= pc4_d;
      rdata_q  <= rdata_d;
      wb_sel_q <= wb_sel_d;
    end
  end

  logic [XLEN-1:0] load_val;

  load_extend #(.XLEN(XLEN)) u_load_extend (
    .rdata_i  (rdata_q),
    .offset_i (alu_q[1:0]),
    .funct3_i (inst_q[14:12]),
    .result_o (load_val)
  );

  logic [XLEN-1:0] wd;
  logic            we;

  always_comb begin
    case (wb_sel_q)
      WB_SEL_MEM: wd = load_val;
      WB_SEL_PC4: wd = pc4_q;
      default:    wd = alu_q;
    endcase
  end

  // rd=0 is excluded here, so forwarding never fires for x0.
  assign we = valid_q & writes_rd(inst_q[6:0]) & (inst_q[11:7] != 5'd0);

  assign bus.rf_we    = we;
  assign bus.rf_wa    = inst_q[7 +: RF_AW];
  assign bus.rf_wd    = wd;
  assign bus.wb_val   = wd;
  assign bus.wb_valid = valid_q;
  assign bus.wb2d_a   = we & (inst_q[7 +: RF_AW] == bus.d_inst[15 +: RF_AW]);
  assign bus.wb2d_b   = we & (inst_q[7 +: RF_AW] == bus.d_inst[20 +: RF_AW]);

`ifdef WB_INSTRET_EN
  logic [63:0] instret_q, instret_d;

  // A flushed edge still retires the instruction that was already sitting in W.
  assign instret_d = (valid_q && !bus.stall) ? instret_q + 64'd1 : instret_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) instret_q <= '0;
    else        instret_q <= instret_d;
  end

  assign bus.instret = instret_q;
`endif

  logic unused_bits;
  assign unused_bits = ^{inst_q[31:15], bus.d_inst[31:25], bus.d_inst[14:0]};

endmodule

// File: doc/writeback_stage.md
Name: writeback_stage

Overview:
- Final (W) stage of the 3-stage RISC-V core.
- Registers the memory-stage result and applies load byte/half extraction and sign/zero extension.
- Selects the write-back value and drives the RegFile write port.
- Generates the MW→D forwarding controls (wb2d_a, wb2d_b, wb_val) consumed by the decode-stage register read.

Parameters:
- XLEN, 32, datapath width.
- RF_AW, 5, register address width.

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  hold W pipeline register
- flush  in  1  invalidate instruction entering W
- m_valid  in  1  M-stage instruction valid
- m_inst  in  32  M-stage instruction
- m_alu  in  XLEN  ALU result / load-store address
- m_pc4  in  XLEN  PC+4 of M-stage instruction
- m_dmem_rdata  in  XLEN  raw DMEM word, valid in same cycle as m_*
- m_wb_sel  in  2  0=ALU, 1=MEM, 2=PC4, 3=ALU
- d_inst  in  32  instruction currently in decode
- rf_we  out  1  RegFile write enable
- rf_wa  out  RF_AW  RegFile write address
- rf_wd  out  XLEN  RegFile write data
- wb_valid  out  1  W holds a valid instruction
- wb2d_a  out  1  forward wb_val to decode rs1
- wb2d_b  out  1  forward wb_val to decode rs2
- wb_val  out  XLEN  forwarded value (equals rf_wd)

Behaviour:
- Clocking and reset:
  - One clock.
  - Reset is asynchronous and active-low (clk, rst_n).
  - During and after reset, all W registers are 0 (valid, inst, alu, pc4, rdata, wb_sel).
  - Reset outputs: rf_we=0, rf_wa=0, rf_wd=0, wb_valid=0, wb2d_a=0, wb2d_b=0, wb_val=0.
- Capture at each rising edge:
  - rst_n low: hold reset values.
  - Else if flush=1: valid←0, other registers don't-care (implementation clears them). Flush has priority over stall.
  - Else if stall=1: all registers hold.
  - Else: register all m_* inputs; valid←m_valid.
- Latency:
  - m_* presented in cycle N produce rf_we/rf_wd combinationally in cycle N+1.
  - The RegFile commits at edge N+2.
- Write-enable qualification:
  - rf_we = valid & writes_rd(opcode) & (rd≠0).
  - writes_rd is true for LUI, AUIPC, JAL, JALR, LOAD, OP-IMM, OP, SYSTEM.
  - writes_rd is false for STORE, BRANCH, MISC-MEM, and any unknown opcode.
  - rf_wa = inst[11:7].
- Load extract, keyed on funct3 = inst[14:12] and byte offset = alu[1:0]:
  - LB/LBU: select byte[offset], then sign- or zero-extend.
  - LH/LHU: select half[offset[1]]; offset[0] is ignored for misaligned accesses (no trap).
  - LW: pass the word through.
  - Any other funct3: pass the word through.
- Value select: rf_wd = wb_val = mux(wb_sel). For wb_sel=3, select ALU.
- Forwarding:
  - wb2d_a = rf_we & (rf_wa == d_inst[19:15]).
  - wb2d_b = rf_we & (rf_wa == d_inst[24:20]).
  - Never asserted for x0, because rf_we already excludes rd=0.
- Stall with a valid instruction: rf_we stays asserted; the rewrite is idempotent and forwarding stays consistent.
- Flush and stall together: flush wins; W becomes a bubble.
- Reset mid-operation: all outputs clear asynchronously with no pending write.

Optional Feature:
- Macro: WB_INSTRET_EN.
- Defined:
  - Adds output instret (64 bits), reset to 0.
  - Increments by 1 on each edge where valid=1 and stall=0, including an edge where flush=1.
  - Wraps from 2^64−1 to 0.
- Undefined: no port and no counter logic.

Decomposition:
- riscv_pkg holds:
  - opcode localparams (OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_OPIMM, OPC_OP, OPC_SYSTEM)
  - load funct3 constants (F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU)
  - WB_SEL_ALU/MEM/PC4 encodings
- Sub-module load_extend: purely combinational (rdata, offset, funct3 → XLEN result).

Test Plan:
- Reset value: hold rst_n=0 with random m_* → all outputs 0. Release rst_n, first cycle → wb_valid=0.
- ADDI: m_inst=ADDI x5,x0,7 with m_alu=7 → next cycle rf_we=1, rf_wa=5, rf_wd=7. With d_inst using rs1=x5 → wb2d_a=1, wb_val=7.
- Load extension: LB with m_alu=0x1002 and rdata=0x80FF1234 → rf_wd=0xFFFFFFFF. LBU at offset 3 → 0x00000080. LH at offset 2 → 0xFFFF80FF. LHU at offset 0 → 0x00001234.
- Non-writing instructions: SW and ADDI to x0 → rf_we=0 and wb2d_a=wb2d_b=0, even when d_inst rs1=rs2=0.
- JAL x1 with m_pc4=0x104 and wb_sel=2 → rf_wd=0x104.
- Stall/flush:
  - stall=1 for 3 cycles → W outputs stay constant.
  - flush=1 together with stall=1 → next cycle wb_valid=0 and rf_we=0.
  - With WB_INSTRET_EN defined, instret counts only the non-stalled valid edges (e.g. 5 instructions, 2 stalls → instret=5).
